// File: rtl/input_buffer_67x4.sv
// Per-input flit FIFO in front of the switch allocator, with head/payload/tail framing check.
// Latency: 1 cycle push to FLIT_out; pop when selected and not nacked; ready_out drops at full and a flit offered then is dropped.
module input_buffer_67x4 #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 67
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             FLIT_in,
    input  logic                         VALID_in,
    output logic                         ready_out,
    output logic [WIDTH-1:0]             FLIT_out,
    output logic                         VALID_out,
    input  logic [5:0]                   sel_in,
    input  logic [5:0]                   nack_in,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         err_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic ST_WAIT_HEAD = 1'b0;
    localparam logic ST_IN_PKT    = 1'b1;

    localparam logic [2:0] TYPE_HEAD    = 3'b011;
    localparam logic [2:0] TYPE_PAYLOAD = 3'b010;
    localparam logic [2:0] TYPE_TAIL    = 3'b000;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             state_q, state_d;
    logic             err_q, err_d;

    logic [2:0] flit_type;
    logic       well_formed;
    logic       push;
    logic       pop;

    assign flit_type = FLIT_in[2:0];
    assign ready_out = (count_q < CW'(DEPTH));
    assign VALID_out = (count_q != '0);
    assign FLIT_out  = mem_q[rd_ptr_q];
    assign count_out = count_q;
    assign err_out   = err_q;

    // Framing legality is judged against the packet state, independent of space.
    always_comb begin
        well_formed = 1'b0;
        if (state_q == ST_WAIT_HEAD) begin
            well_formed = (flit_type == TYPE_HEAD);
        end else begin
            well_formed = (flit_type == TYPE_PAYLOAD) || (flit_type == TYPE_TAIL);
        end
    end

    assign push = VALID_in & ready_out & well_formed;
    assign pop  = VALID_out & (|sel_in) & ~(|nack_in);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        err_d    = VALID_in & ~push;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (flit_type == TYPE_HEAD) begin
                state_d = ST_IN_PKT;
            end else if (flit_type == TYPE_TAIL) begin
                state_d = ST_WAIT_HEAD;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_WAIT_HEAD;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            err_q    <= err_d;
        end
    end

    // Flit storage carries no reset; VALID_out qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= FLIT_in;
        end
    end

endmodule

// File: tb/tb_input_buffer_67x4.sv
// Directed bench for input_buffer_67x4: vector table for framing, fill and nack cases,
// plus hand sequences for pointer wrap and mid-packet reset.
module tb_input_buffer_67x4;
    localparam int W = 67;

    logic         clk;
    logic         rst;
    logic [W-1:0] flit_in;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] flit_out;
    logic         valid_out;
    logic [5:0]   sel_in;
    logic [5:0]   nack_in;
    logic [2:0]   count_out;
    logic         err_out;

    int n_vec = 0;
    int n_bad = 0;

    input_buffer_67x4 dut (
        .clk       (clk),
        .rst       (rst),
        .FLIT_in   (flit_in),
        .VALID_in  (valid_in),
        .ready_out (ready_out),
        .FLIT_out  (flit_out),
        .VALID_out (valid_out),
        .sel_in    (sel_in),
        .nack_in   (nack_in),
        .count_out (count_out),
        .err_out   (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         vin;
        logic [W-1:0] flit;
        logic [5:0]   sel;
        logic [5:0]   nack;
        logic         e_rdy;
        logic         e_vld;
        logic [W-1:0] e_flit;
        logic [2:0]   e_cnt;
        logic         e_err;
    } vec_t;

    vec_t tbl [40];
    int   nrow = 0;

    function automatic logic [W-1:0] mkf(input int tag, input int dst, input int typ);
        return {61'(tag), 3'(dst), 3'(typ)};
    endfunction

    task automatic row(input logic vin, input logic [W-1:0] f, input logic [5:0] s,
                       input logic [5:0] n, input logic er, input logic ev,
                       input logic [W-1:0] ef, input logic [2:0] ec, input logic ee);
        tbl[nrow].vin    = vin;
        tbl[nrow].flit   = f;
        tbl[nrow].sel    = s;
        tbl[nrow].nack   = n;
        tbl[nrow].e_rdy  = er;
        tbl[nrow].e_vld  = ev;
        tbl[nrow].e_flit = ef;
        tbl[nrow].e_cnt  = ec;
        tbl[nrow].e_err  = ee;
        nrow++;
    endtask

    task automatic check(input string name, input logic e_rdy, input logic e_vld,
                         input logic [W-1:0] e_flit, input logic [2:0] e_cnt, input logic e_err);
        logic bad;
        bad = (ready_out !== e_rdy) || (valid_out !== e_vld) ||
              (count_out !== e_cnt) || (err_out !== e_err) ||
              (e_vld && (flit_out !== e_flit));
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b vld=%b cnt=%0d err=%b flit=%h, want rdy=%b vld=%b cnt=%0d err=%b flit=%h",
                     name, ready_out, valid_out, count_out, err_out, flit_out,
                     e_rdy, e_vld, e_cnt, e_err, e_flit);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check state after the rising edge.
    task automatic step(input string name, input logic vin, input logic [W-1:0] f,
                        input logic [5:0] s, input logic [5:0] n,
                        input logic er, input logic ev, input logic [W-1:0] ef,
                        input logic [2:0] ec, input logic ee);
        @(negedge clk);
        valid_in = vin;
        flit_in  = f;
        sel_in   = s;
        nack_in  = n;
        @(posedge clk);
        #1;
        check(name, er, ev, ef, ec, ee);
    endtask

    logic [W-1:0] z;
    logic [W-1:0] h1, p1, t1, h2, p2a, p2b, t2, h3, h4, t4, xp, h5, h6, bad7, p5, t5;

    initial begin
        z    = '0;
        h1   = mkf(1, 1, 3);
        p1   = mkf(2, 1, 2);
        t1   = mkf(3, 1, 0);
        h2   = mkf(4, 2, 3);
        p2a  = mkf(5, 2, 2);
        p2b  = mkf(6, 2, 2);
        t2   = mkf(7, 2, 0);
        h3   = mkf(8, 0, 3);
        h4   = mkf(9, 3, 3);
        t4   = mkf(10, 3, 0);
        xp   = mkf(11, 0, 2);
        h5   = mkf(12, 4, 3);
        h6   = mkf(13, 4, 3);
        bad7 = mkf(14, 4, 7);
        p5   = mkf(15, 4, 2);
        t5   = mkf(16, 4, 0);

        // pass-through with continuous select
        row(1, h1,   6'd2, 6'd0, 1, 1, h1,  3'd1, 0);
        row(1, p1,   6'd2, 6'd0, 1, 1, p1,  3'd1, 0);
        row(1, t1,   6'd2, 6'd0, 1, 1, t1,  3'd1, 0);
        row(0, z,    6'd2, 6'd0, 1, 0, z,   3'd0, 0);
        // fill, overflow drop, drain
        row(1, h2,   6'd0, 6'd0, 1, 1, h2,  3'd1, 0);
        row(1, p2a,  6'd0, 6'd0, 1, 1, h2,  3'd2, 0);
        row(1, p2b,  6'd0, 6'd0, 1, 1, h2,  3'd3, 0);
        row(1, t2,   6'd0, 6'd0, 0, 1, h2,  3'd4, 0);
        row(1, h3,   6'd0, 6'd0, 0, 1, h2,  3'd4, 1);
        row(0, z,    6'd1, 6'd0, 1, 1, p2a, 3'd3, 0);
        row(0, z,    6'd1, 6'd0, 1, 1, p2b, 3'd2, 0);
        row(0, z,    6'd1, 6'd0, 1, 1, t2,  3'd1, 0);
        row(0, z,    6'd1, 6'd0, 1, 0, z,   3'd0, 0);
        // nack hold, then release
        row(1, h4,   6'd0, 6'd0, 1, 1, h4,  3'd1, 0);
        row(0, z,    6'd4, 6'd4, 1, 1, h4,  3'd1, 0);
        row(0, z,    6'd4, 6'd4, 1, 1, h4,  3'd1, 0);
        row(0, z,    6'd4, 6'd4, 1, 1, h4,  3'd1, 0);
        row(0, z,    6'd4, 6'd0, 1, 0, z,   3'd0, 0);
        // framing errors
        row(1, t4,   6'd0, 6'd0, 1, 1, t4,  3'd1, 0);
        row(1, xp,   6'd0, 6'd0, 1, 1, t4,  3'd1, 1);
        row(1, h5,   6'd0, 6'd0, 1, 1, t4,  3'd2, 0);
        row(1, h6,   6'd0, 6'd0, 1, 1, t4,  3'd2, 1);
        row(1, bad7, 6'd0, 6'd0, 1, 1, t4,  3'd2, 1);
        row(1, p5,   6'd0, 6'd0, 1, 1, t4,  3'd3, 0);
        row(1, t5,   6'd0, 6'd0, 0, 1, t4,  3'd4, 0);
        row(0, z,    6'd1, 6'd0, 1, 1, h5,  3'd3, 0);
        row(0, z,    6'd1, 6'd0, 1, 1, p5,  3'd2, 0);
        row(0, z,    6'd1, 6'd0, 1, 1, t5,  3'd1, 0);
        row(0, z,    6'd1, 6'd0, 1, 0, z,   3'd0, 0);

        rst      = 1'b0;
        valid_in = 1'b0;
        flit_in  = '0;
        sel_in   = '0;
        nack_in  = '0;
        #3;
        check("reset_state", 1, 0, z, 3'd0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 1, 0, z, 3'd0, 0);

        for (int i = 0; i < nrow; i++) begin
            step($sformatf("vec%0d", i), tbl[i].vin, tbl[i].flit, tbl[i].sel, tbl[i].nack,
                 tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_flit, tbl[i].e_cnt, tbl[i].e_err);
        end

        // simultaneous push/pop across several pointer wraps
        step("wrap_head", 1, mkf(100, 5, 3), 6'd0, 6'd0, 1, 1, mkf(100, 5, 3), 3'd1, 0);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("wrap%0d", i), 1, mkf(101 + i, 5, 2), 6'd1, 6'd0,
                 1, 1, mkf(101 + i, 5, 2), 3'd1, 0);
        end
        step("pre_reset_cnt2", 1, mkf(120, 5, 2), 6'd0, 6'd0, 1, 1, mkf(110, 5, 2), 3'd2, 0);

        // asynchronous reset mid-packet
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b0;
        #1;
        check("async_reset", 1, 0, z, 3'd0, 0);
        @(negedge clk);
        rst = 1'b1;
        step("payload_after_reset", 1, mkf(121, 5, 2), 6'd0, 6'd0, 1, 0, z, 3'd0, 1);
        step("head_after_reset", 1, mkf(130, 0, 3), 6'd0, 6'd0, 1, 1, mkf(130, 0, 3), 3'd1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/input_buffer_67x4.md
# input_buffer_67x4

Per-input-port flit buffer sitting directly upstream of the 6x6 switch allocator. It stores incoming 67-bit flits in a small FIFO, checks packet framing (head, payloads, tail), and presents the oldest flit to the six output-port allocators. It pops that flit only when an allocator has selected this input and none of the allocators signals not-accept.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- WIDTH, 67, flit width. Bits [2:0] are the type: 011 head, 010 payload, 000 tail; any other code is illegal. Bits [5:3] are the destination port.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- FLIT_in  in  WIDTH  flit from the upstream link.
- VALID_in  in  1  FLIT_in is valid this cycle.
- ready_out  out  1  buffer can accept a flit this cycle.
- FLIT_out  out  WIDTH  oldest buffered flit, to FLIT_in__k of every allocator.
- VALID_out  out  1  FLIT_out is valid, to VALID_in__k of every allocator.
- sel_in  in  6  bit j is select[k] of output allocator j.
- nack_in  in  6  bit j is BWDAUX1_out[k] of output allocator j.
- count_out  out  clog2(DEPTH+1)  current occupancy.
- err_out  out  1  one-cycle pulse when an incoming flit is dropped.

## Operation
- Storage: WIDTH x DEPTH register array, no reset on the array. Write pointer wr_ptr and read pointer rd_ptr each wrap modulo DEPTH. Occupancy count ranges 0..DEPTH.
- ready_out = (count < DEPTH). It is combinational from registered count and does not look ahead to a same-cycle pop.
- VALID_out = (count != 0). FLIT_out = mem[rd_ptr]. FLIT_out is don't-care while VALID_out = 0.
- pop = VALID_out & |sel_in & ~|nack_in.
- Framing FSM has two states:
  - WAIT_HEAD: accepts only head flits; an accepted head moves to IN_PKT.
  - IN_PKT: accepts payload and tail flits; payload stays in IN_PKT; tail returns to WAIT_HEAD.
- A flit is "well-formed" when it is legal for the current FSM state.
- push = VALID_in & ready_out & well-formed. On push: the flit is written at wr_ptr, wr_ptr increments, and the FSM advances.
- Drop conditions (flit not written, err_out = 1 next cycle):
  - VALID_in & ~ready_out. This is an overflow; the FSM does not advance.
  - VALID_in & ready_out & ~well-formed. Covers a non-head in WAIT_HEAD, a head in IN_PKT, or an illegal type code. The FSM does not advance.
- count update: next = count + push − pop. Push and pop in the same cycle leave count unchanged and advance both pointers.
- Destination bits are passed through unmodified; the allocators perform the match.

## Timing
- Reset (rst = 0, asynchronous) forces:
  - count = 0, wr_ptr = 0, rd_ptr = 0, FSM = WAIT_HEAD.
  - VALID_out = 0, ready_out = 1, count_out = 0, err_out = 0.
- Reset mid-packet discards all buffered flits and framing state. The first flit accepted after reset must be a head.
- Latency: a flit pushed at edge N is visible on FLIT_out/VALID_out after edge N (cut-through is not allowed). Minimum in-to-out latency is 1 cycle.
- Pop takes effect at the edge where pop = 1. The next flit, if any, appears on FLIT_out after that edge.
- Throughput is 1 flit per cycle in steady state with simultaneous push and pop.
- Full (count = DEPTH): ready_out = 0 and no push occurs, even if a pop happens that cycle. Space is visible one cycle later.
- Empty (count = 0): no pop occurs regardless of sel_in and nack_in.
- err_out is registered: high for exactly one cycle following each dropped flit, and high again on consecutive cycles for consecutive drops.
- Pointer wrap from DEPTH−1 to 0 must preserve FIFO order.

## Test plan
- Reset then idle: after rst deasserts, ready_out = 1, VALID_out = 0, count_out = 0, err_out = 0.
- Packet pass-through: push head 0x…0B (port 1, type 011), payload 0x…0A, tail 0x…08, with sel_in = 6'b000010 and nack_in = 0 continuously. Each flit appears on FLIT_out one cycle after push, in order; count_out never exceeds 1.
- Fill and backpressure: sel_in = 0, push 4 flits of one packet. count_out = 4 and ready_out = 0. A fifth VALID_in gives err_out = 1 for one cycle and that flit is absent later. Then sel_in = 6'b000001 for 4 cycles drains exactly the 4 flits in order.
- Nack hold: VALID_out = 1 with sel_in = 6'b000100 and nack_in = 6'b000100 for 3 cycles. FLIT_out is unchanged and count_out is constant. Clearing nack_in pops on the next edge.
- Framing errors: in WAIT_HEAD, push a payload flit, which drops with err_out = 1 and count unchanged. Push a head then another head: the second drops. Push type 3'b111: it drops. Subsequent payload and tail are accepted.
- Wrap and reset: push and pop simultaneously for 10 cycles; data order is preserved across pointer wrap. Asserting rst mid-packet with count = 2 gives count_out = 0 and VALID_out = 0 immediately. A payload flit right after reset is dropped.
